// File: rtl/wii_nunchuk_reader.sv
// -----------------------------------------------------------------------------
// wii_nunchuk_reader
//   I2C master that initialises a Wii Nunchuk, then polls it forever:
//     INIT0 (F0<-55) -> INIT1 (FB<-00) -> { PTR (00) -> READ 6 bytes }
//   with CONV_CYCLES after each write and POLL_CYCLES after each read.
//   SCL/SDA are open-drain: an *_oe of 1 pulls the pad low, 0 releases it.
//   Each bit is four quarters of QTR clocks: q0 SCL low (SDA changes),
//   q1 SCL released, q2 SCL high (sda_in sampled on its last cycle),
//   q3 SCL pulled low. Clock stretching is not supported.
//
// Optional feature (macro WII_ACK_CHECK_EN):
//   defined   - an address/data NACK on a write, or an address NACK on a
//               read, ends the transaction with STOP, sets nack_err (sticky),
//               suppresses the wii_data update and restarts at INIT0 after
//               POLL_CYCLES.
//   undefined - ACK samples are ignored; nack_err is tied low.
//
// Ports:
//   clock      in   system clock (100 MHz pixel clock)
//   reset      in   synchronous, active-high
//   sda_in     in   sampled SDA pad level
//   scl_oe     out  1 = pull SCL low
//   sda_oe     out  1 = pull SDA low
//   wii_data   out  last complete sample, byte0 at [47:40] .. byte5 at [7:0]
//   data_valid out  one-cycle pulse when wii_data is loaded
//   busy       out  high from START through STOP
//   nack_err   out  sticky NACK flag
// -----------------------------------------------------------------------------
module wii_nunchuk_reader #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned I2C_FREQ       = 100_000,
  parameter logic [6:0]  DEV_ADDR       = 7'h52,
  parameter int unsigned STARTUP_CYCLES = 10_000_000,
  parameter int unsigned CONV_CYCLES    = 100_000,
  parameter int unsigned POLL_CYCLES    = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [47:0] wii_data,
  output logic        data_valid,
  output logic        busy,
  output logic        nack_err
);

  localparam int unsigned QTR = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned TW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_TX_BYTE, ST_RX_ACK,
    ST_RX_BYTE, ST_TX_ACK, ST_STOP, ST_WAIT
  } state_t;

  typedef enum logic [1:0] {SEQ_INIT0, SEQ_INIT1, SEQ_PTR, SEQ_READ} step_t;

  state_t        state, state_next;
  step_t         step;
  logic [TW-1:0] tick;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_cnt;    // write: byte index; read: 1..6 for data bytes
  logic [31:0]   wait_cnt;
  logic [31:0]   wait_len;
  logic          long_wait;   // next WAIT uses POLL_CYCLES instead of CONV_CYCLES
  logic [47:0]   shadow;
  logic [7:0]    tx_byte;
  logic          q_end, sample, bit_end, last_tx, scl_low_q;
  logic          nack_hit, txn_err;

  assign q_end     = (tick == TW'(QTR - 1));
  assign sample    = q_end && (quarter == 2'd2);
  assign bit_end   = q_end && (quarter == 2'd3);
  assign scl_low_q = (quarter == 2'd0) || (quarter == 2'd3);
  assign last_tx   = (step == SEQ_PTR) ? (byte_cnt == 3'd1) : (byte_cnt == 3'd2);
  assign wait_len  = long_wait ? POLL_CYCLES : CONV_CYCLES;

  // Byte to transmit for the current sequencer step and byte index.
  always_comb begin
    tx_byte = {DEV_ADDR, 1'b0};
    case (step)
      SEQ_INIT0: if (byte_cnt == 3'd1) tx_byte = 8'hF0;
                 else if (byte_cnt == 3'd2) tx_byte = 8'h55;
      SEQ_INIT1: if (byte_cnt == 3'd1) tx_byte = 8'hFB;
                 else if (byte_cnt == 3'd2) tx_byte = 8'h00;
      SEQ_PTR:   if (byte_cnt == 3'd1) tx_byte = 8'h00;
      default:   tx_byte = {DEV_ADDR, 1'b1};
    endcase
  end

`ifdef WII_ACK_CHECK_EN
  logic ack_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_bit  <= 1'b0;
      txn_err  <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      if (state == ST_RX_ACK && sample) ack_bit <= sda_in;
      if (state == ST_RX_ACK && bit_end && ack_bit) begin
        txn_err  <= 1'b1;
        nack_err <= 1'b1;
      end else if (state == ST_STOP && bit_end) begin
        txn_err <= 1'b0;
      end
    end
  end

  assign nack_hit = ack_bit;
`else
  assign nack_hit = 1'b0;
  assign txn_err  = 1'b0;
  assign nack_err = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of the others, independent of process order.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment on entry keeps this purely combinational;
  // a path that leaves state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (wait_cnt == STARTUP_CYCLES - 1) state_next = ST_START;
      ST_START:   if (bit_end) state_next = ST_TX_BYTE;
      ST_TX_BYTE: if (bit_end && bit_cnt == 3'd7) state_next = ST_RX_ACK;
      ST_RX_ACK:
        if (bit_end) begin
          if (nack_hit || (step != SEQ_READ && last_tx)) state_next = ST_STOP;
          else if (step == SEQ_READ)                     state_next = ST_RX_BYTE;
          else                                           state_next = ST_TX_BYTE;
        end
      ST_RX_BYTE: if (bit_end && bit_cnt == 3'd7) state_next = ST_TX_ACK;
      ST_TX_ACK:  if (bit_end) state_next = (byte_cnt == 3'd6) ? ST_STOP : ST_RX_BYTE;
      ST_STOP:    if (bit_end) state_next = ST_WAIT;
      ST_WAIT:    if (wait_cnt == wait_len - 1) state_next = ST_START;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Pad drive and busy, decoded from state and quarter.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    busy   = (state != ST_IDLE) && (state != ST_WAIT);
    case (state)
      ST_START: begin
        sda_oe = quarter[1];               // falls while SCL is high
        scl_oe = (quarter == 2'd3);
      end
      ST_TX_BYTE: begin
        scl_oe = scl_low_q;
        sda_oe = ~tx_byte[3'd7 - bit_cnt];
      end
      ST_RX_ACK, ST_RX_BYTE: scl_oe = scl_low_q;
      ST_TX_ACK: begin
        scl_oe = scl_low_q;
        sda_oe = (byte_cnt != 3'd6);       // NACK the final byte
      end
      ST_STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = ~quarter[1];              // rises while SCL is high
      end
      default: ;
    endcase
  end

  // Timing counters, receive shift register and sequencer.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick       <= '0;
      quarter    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      wait_cnt   <= '0;
      step       <= SEQ_INIT0;
      long_wait  <= 1'b0;
      shadow     <= '0;
      wii_data   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state == ST_IDLE || state == ST_WAIT) begin
        tick     <= '0;
        quarter  <= '0;
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
        if (q_end) begin
          tick    <= '0;
          quarter <= quarter + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end

      if ((state == ST_TX_BYTE || state == ST_RX_BYTE) && bit_end)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == ST_START)
        byte_cnt <= '0;
      else if ((state == ST_RX_ACK || state == ST_TX_ACK) && bit_end)
        byte_cnt <= byte_cnt + 1'b1;

      // Six bytes shifted in MSB first leave byte0 in the top octet.
      if (state == ST_RX_BYTE && sample)
        shadow <= {shadow[46:0], sda_in};

      if (state == ST_STOP && bit_end) begin
        if (txn_err) begin
          step      <= SEQ_INIT0;
          long_wait <= 1'b1;
        end else begin
          long_wait <= (step == SEQ_READ);
          case (step)
            SEQ_INIT0: step <= SEQ_INIT1;
            SEQ_INIT1: step <= SEQ_PTR;
            SEQ_PTR:   step <= SEQ_READ;
            default:   step <= SEQ_PTR;
          endcase
          if (step == SEQ_READ) begin
            wii_data   <= shadow;
            data_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wii_nunchuk_reader.sv
// -----------------------------------------------------------------------------
// tb_wii_nunchuk_reader
//   Directed bench: a behavioural I2C slave watches the open-drain bus, logs
//   every byte, ACKs, and serves six read bytes. QTR=1, STARTUP=8, CONV=20,
//   POLL=50. Builds with or without WII_ACK_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_wii_nunchuk_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sda_in;
  logic        scl_oe, sda_oe;
  logic [47:0] wii_data;
  logic        data_valid, busy, nack_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wii_nunchuk_reader #(
    .CLK_FREQ(400), .I2C_FREQ(100), .DEV_ADDR(7'h52),
    .STARTUP_CYCLES(8), .CONV_CYCLES(20), .POLL_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .wii_data(wii_data),
    .data_valid(data_valid), .busy(busy), .nack_err(nack_err)
  );

  // ---------------- slave model ----------------
  logic       slave_low = 1'b0;
  logic       nack_read_addr = 1'b0;
  logic [7:0] rd_data [6];
  logic [7:0] bus_bytes [$];
  logic       mack [$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;

  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       m_scl, m_sda;
  logic       s_active = 1'b0, s_skip = 1'b0, s_first = 1'b0;
  logic       s_read = 1'b0, s_acked = 1'b0, mack_last = 1'b1;
  int         s_bit = 0, s_rd_idx = 0;
  logic [7:0] s_shift = 8'h00, rd_cur = 8'h00;

  assign sda_in = ~sda_oe & ~slave_low;

  always @(negedge clock) begin
    m_scl = ~scl_oe;
    m_sda = sda_in;
    if (reset) begin
      s_active  = 1'b0;
      slave_low = 1'b0;
      s_bit     = 0;
      s_skip    = 1'b0;
    end else if (prev_scl && m_scl && prev_sda && !m_sda) begin
      start_cnt++;
      s_active = 1'b1; s_skip = 1'b1; s_first = 1'b1; s_read = 1'b0;
      s_bit = 0; s_rd_idx = 0; slave_low = 1'b0;
    end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
      stop_cnt++;
      s_active = 1'b0; slave_low = 1'b0;
    end else if (s_active && !prev_scl && m_scl) begin
      if (s_bit < 8) s_shift = {s_shift[6:0], m_sda};
      else if (s_read && !s_first) begin
        mack.push_back(m_sda);
        mack_last = m_sda;
      end
    end else if (s_active && prev_scl && !m_scl) begin
      if (s_skip) s_skip = 1'b0;
      else begin
        s_bit++;
        if (s_bit == 8) begin
          bus_bytes.push_back(s_shift);
          if (s_first) begin
            s_read    = s_shift[0];
            s_acked   = !(s_shift[0] && nack_read_addr);
            slave_low = s_acked;
          end else begin
            slave_low = !s_read;
          end
        end else if (s_bit == 9) begin
          s_bit = 0;
          if (s_read && s_acked && s_rd_idx < 6 && (s_first || !mack_last)) begin
            rd_cur    = rd_data[s_rd_idx];
            s_rd_idx++;
            slave_low = !rd_cur[7];
          end else begin
            slave_low = 1'b0;
          end
          s_first = 1'b0;
        end else if (s_read && !s_first && s_acked) begin
          slave_low = !rd_cur[7 - s_bit];
        end else begin
          slave_low = 1'b0;
        end
      end
    end
    prev_scl = m_scl;
    prev_sda = ~sda_oe & ~slave_low;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stops(input int n, input string tag);
    int k = 0;
    while (stop_cnt < n && k < 5000) begin
      @(negedge clock);
      k++;
    end
    check(tag, 48'(stop_cnt >= n), 48'd1);
  endtask

  // exp holds up to 7 bytes, first expected byte in [55:48].
  task automatic check_bytes(input string tag, input int base, input int n, input logic [55:0] exp);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), 48'(bus_bytes[base + i]), 48'(exp[55 - 8*i -: 8]));
  endtask

  task automatic count_to_busy(output int n);
    n = 0;
    while (!busy && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_valid(input string tag, input logic [47:0] hold, output logic [47:0] got);
    int   k         = 0;
    logic prev_busy = 1'b0;
    logic held      = 1'b1;
    logic seen      = 1'b0;
    while (!seen && k < 5000) begin
      @(negedge clock);
      k++;
      if (data_valid) seen = 1'b1;
      else begin
        if (wii_data !== hold) held = 1'b0;
        prev_busy = busy;
      end
    end
    check({tag, "_seen"}, 48'(seen), 48'd1);
    check({tag, "_held"}, 48'(held), 48'd1);
    check({tag, "_busy_fall"}, {46'd0, prev_busy, busy}, 48'b10);
    got = wii_data;
    @(negedge clock);
    check({tag, "_pulse_len"}, 48'(data_valid), 48'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [47:0] got;
    logic [5:0]  exp_ack;
    int          n, base, mbase, s0, k;
    logic        dv_seen;

    rd_data = '{8'h7F, 8'h80, 8'h12, 8'h34, 8'h56, 8'h03};

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_scl_oe", 48'(scl_oe), 48'd0);
    check("rst_sda_oe", 48'(sda_oe), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_valid", 48'(data_valid), 48'd0);
    check("rst_data", wii_data, 48'd0);
    check("rst_nack", 48'(nack_err), 48'd0);

    // Startup delay, then INIT0 / INIT1 / PTR.
    reset = 1'b0;
    count_to_busy(n);
    check("startup_cycles", 48'(n), 48'd8);
    wait_stops(1, "init0_stop");
    check("first_start", 48'(start_cnt), 48'd1);
    check_bytes("init0", 0, 3, 56'hA4F055_00000000);
    wait_stops(2, "init1_stop");
    check_bytes("init1", 3, 3, 56'hA4FB00_00000000);
    wait_stops(3, "ptr_stop");
    check_bytes("ptr", 6, 2, 56'hA400_0000000000);

    // First read.
    mbase = mack.size();
    wait_valid("read1", 48'h0, got);
    check("read1_data", got, 48'h7F80_1234_5603);
    check_bytes("read1", 8, 7, 56'hA57F8012345603);
    exp_ack = 6'b000001;
    for (int i = 0; i < 6; i++)
      check($sformatf("read1_mack%0d", i), 48'(mack[mbase + i]), 48'(exp_ack[5 - i]));
    rd_data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    k = 0;
    while (!busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("poll_gap", 48'(k + 1 >= 50), 48'd1);

    // Second read: old value held until the pulse.
    wait_valid("read2", 48'h7F80_1234_5603, got);
    check("read2_data", got, 48'h0);

    // Third read: slave NACKs the read address.
    nack_read_addr = 1'b1;
    base = bus_bytes.size();
    s0   = stop_cnt;
`ifdef WII_ACK_CHECK_EN
    wait_stops(s0 + 2, "nack_stop");
    dv_seen = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
      if (data_valid) dv_seen = 1'b1;
    end
    check("nack_no_valid", 48'(dv_seen | data_valid), 48'd0);
    check("nack_err_set", 48'(nack_err), 48'd1);
    check("nack_byte_cnt", 48'(bus_bytes.size() - base), 48'd3);
    check_bytes("nack_txn", base, 3, 56'hA400A5_00000000);
    nack_read_addr = 1'b0;
    rd_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    k = 0;
    while (!busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("nack_gap", 48'(k >= 50), 48'd1);
    base = bus_bytes.size();
    wait_stops(stop_cnt + 1, "reinit_stop");
    check_bytes("reinit", base, 3, 56'hA4F055_00000000);
`else
    wait_valid("read3", 48'h0, got);
    check("read3_data", got, 48'hFFFF_FFFF_FFFF);
    check("read3_nack_err", 48'(nack_err), 48'd0);
    check_bytes("read3", base, 3, 56'hA400A5_00000000);
    nack_read_addr = 1'b0;
    rd_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
`endif

    // Reset during bit 3 of read byte 2.
    k = 0;
    while (!(s_active && s_read && s_acked && s_rd_idx == 3 && s_bit == 3) && k < 5000) begin
      @(negedge clock);
      k++;
    end
    check("abort_reached", 48'(busy), 48'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_scl_oe", 48'(scl_oe), 48'd0);
    check("abort_sda_oe", 48'(sda_oe), 48'd0);
    check("abort_busy", 48'(busy), 48'd0);
    check("abort_valid", 48'(data_valid), 48'd0);
    check("abort_data", wii_data, 48'd0);
    check("abort_nack", 48'(nack_err), 48'd0);
    @(negedge clock);
    reset = 1'b0;
    base  = bus_bytes.size();
    count_to_busy(n);
    check("restart_cycles", 48'(n), 48'd8);
    wait_stops(stop_cnt + 1, "restart_stop");
    check_bytes("restart", base, 3, 56'hA4F055_00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
